// File: rtl/keypad_entry.sv
// keypad_entry: keypad scanner consumer. Debounces each press and release,
// acknowledges every accepted press once, builds a BCD digit entry and, on
// '#', converts it to binary and offers it with a valid/taken handshake.
// Build option: define KEYPAD_BACKSPACE_EN to make '*' a backspace;
// otherwise '*' clears the whole entry.
module keypad_entry #(
  parameter int MAX_DIGITS    = 6,
  parameter int VALUE_W       = 20,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                buttonPressed,
  output logic [31:0]               acknowledgeKey,
  input  logic                      entry_taken,
  output logic                      entry_valid,
  output logic [VALUE_W-1:0]        entry_value,
  output logic [4*MAX_DIGITS-1:0]   entry_bcd,
  output logic [3:0]                digit_count
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Same threshold serves both filters: the press filter counts repeats after
  // the capture sample, the release filter counts every no-key sample.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_DIGITS);
  localparam logic [3:0]       KEY_STAR  = 4'd10;
  localparam logic [3:0]       KEY_ENTER = 4'd11;
  localparam logic [3:0]       KEY_NONE  = 4'd13;

  typedef enum logic [2:0] {
    IDLE, STABLE, APPLY, WAIT_RELEASE, CONVERT, DONE
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [3:0]         code_reg;
  logic               pending_reg;
  logic               ack_reg;
  logic [VALUE_W-1:0] acc_reg;
  logic [3:0]         step_reg;

  // Digits viewed as an array, padded with zeros so any 4-bit index is safe.
  logic [3:0] digit_at [16];
  logic [3:0] oldest_pos;
  logic [3:0] next_digit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_digit
      if (gi < MAX_DIGITS) begin : g_used
        assign digit_at[gi] = entry_bcd[4*gi +: 4];
      end else begin : g_pad
        assign digit_at[gi] = 4'd0;
      end
    end
  endgenerate

  // Conversion walks from the oldest digit (highest nibble) to the newest.
  assign oldest_pos = digit_count - 4'd1 - step_reg;
  assign next_digit = digit_at[oldest_pos];

  assign acknowledgeKey = {31'd0, ack_reg};

  // Main control: debounce, apply key, release filter, convert, handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      code_reg    <= 4'd0;
      pending_reg <= 1'b0;
      ack_reg     <= 1'b0;
      acc_reg     <= '0;
      step_reg    <= 4'd0;
      entry_valid <= 1'b0;
      entry_value <= '0;
      entry_bcd   <= '0;
      digit_count <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (buttonPressed <= KEY_ENTER) begin
            code_reg  <= buttonPressed;
            cnt_reg   <= '0;
            state_reg <= STABLE;
          end
        end

        STABLE: begin
          if (buttonPressed != code_reg) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg + CNT_W'(1) == CNT_LAST) state_reg <= APPLY;
          end
        end

        APPLY: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_RELEASE;
          if (code_reg <= 4'd9) begin
            if (digit_count < MAX_CNT) begin
              entry_bcd   <= (entry_bcd << 4) | BCD_W'(code_reg);
              digit_count <= digit_count + 4'd1;
            end
          end else if (code_reg == KEY_STAR) begin
            pending_reg <= 1'b0;
`ifdef KEYPAD_BACKSPACE_EN
            if (digit_count != 4'd0) begin
              entry_bcd   <= entry_bcd >> 4;
              digit_count <= digit_count - 4'd1;
            end
`else
            entry_bcd   <= '0;
            digit_count <= 4'd0;
`endif
          end else if (code_reg == KEY_ENTER) begin
            if (digit_count != 4'd0) pending_reg <= 1'b1;
          end
        end

        WAIT_RELEASE: begin
          if (buttonPressed == KEY_NONE) begin
            if (cnt_reg == CNT_LAST) begin
              ack_reg   <= 1'b0;
              cnt_reg   <= '0;
              acc_reg   <= '0;
              step_reg  <= 4'd0;
              state_reg <= pending_reg ? CONVERT : IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
              ack_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= '0;
            ack_reg <= 1'b1;
          end
        end

        CONVERT: begin
          if (step_reg == digit_count) begin
            entry_value <= acc_reg;
            pending_reg <= 1'b0;
            entry_valid <= 1'b1;
            state_reg   <= DONE;
          end else begin
            acc_reg  <= acc_reg * VALUE_W'(10) + VALUE_W'(next_digit);
            step_reg <= step_reg + 4'd1;
          end
        end

        DONE: begin
          if (entry_taken) begin
            entry_bcd   <= '0;
            digit_count <= 4'd0;
            entry_valid <= 1'b0;
            state_reg   <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed test of keypad_entry with hand-computed results.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  buttonPressed;
  logic [31:0] acknowledgeKey;
  logic        entry_taken;
  logic        entry_valid;
  logic [19:0] entry_value;
  logic [23:0] entry_bcd;
  logic [3:0]  digit_count;

  int checks   = 0;
  int failures = 0;
  int ack_rises = 0;
  logic ack_prev = 1'b0;

  keypad_entry #(.MAX_DIGITS(6), .VALUE_W(20), .STABLE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .buttonPressed (buttonPressed),
    .acknowledgeKey(acknowledgeKey),
    .entry_taken   (entry_taken),
    .entry_valid   (entry_valid),
    .entry_value   (entry_value),
    .entry_bcd     (entry_bcd),
    .digit_count   (digit_count)
  );

  always #5 clock = ~clock;

  // Count acknowledge rising edges as seen on the sampling edge.
  always @(negedge clock) begin
    if (acknowledgeKey[0] && !ack_prev) ack_rises <= ack_rises + 1;
    ack_prev <= acknowledgeKey[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", tag, got, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold a code, then release to no-key for gap cycles.
  task automatic press(input logic [3:0] code, input int hold, input int gap);
    buttonPressed = code;
    cycles(hold);
    buttonPressed = 4'd13;
    cycles(gap);
  endtask

  task automatic wait_ack(input string tag, input logic lvl);
    int n = 0;
    while (acknowledgeKey[0] !== lvl && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(acknowledgeKey[0]), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (entry_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(entry_valid), 32'd1);
  endtask

  task automatic take();
    entry_taken = 1'b1;
    cycles(1);
    entry_taken = 1'b0;
    cycles(1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    buttonPressed = 4'd13;
    entry_taken = 1'b0;
    cycles(3);
    check("reset_ack", acknowledgeKey, 32'd0);
    check("reset_valid", 32'(entry_valid), 32'd0);
    check("reset_value", 32'(entry_value), 32'd0);
    check("reset_count", 32'(digit_count), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Press/release timing for a single '7'
    buttonPressed = 4'd7;
    cycles(5);
    check("ack_before_k+5", acknowledgeKey, 32'd0);
    cycles(1);
    check("ack_at_k+5", acknowledgeKey, 32'd1);
    buttonPressed = 4'd13;
    cycles(3);
    check("ack_held_r+2", acknowledgeKey, 32'd1);
    cycles(1);
    check("ack_low_r+3", acknowledgeKey, 32'd0);
    check("bcd_after_7", 32'(entry_bcd), 32'h7);
    press(4'd10, 10, 10);
    check("count_after_star", 32'(digit_count), 32'd0);

    // Basic entry 1,2,3,4,#
    base = ack_rises;
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    press(4'd3, 10, 10);
    press(4'd4, 10, 10);
    check("basic_acks", 32'(ack_rises - base), 32'd4);
    check("basic_bcd", 32'(entry_bcd), 32'h001234);
    check("basic_count", 32'(digit_count), 32'd4);
    buttonPressed = 4'd11;
    cycles(10);
    buttonPressed = 4'd13;
    wait_ack("basic_enter_ack_fall", 1'b0);
    wait_valid("basic_valid", n);
    check("basic_enter_latency", 32'(n), 32'd5);
    check("basic_value", 32'(entry_value), 32'd1234);
    check("basic_enter_ack_count", 32'(ack_rises - base), 32'd5);
    take();
    check("taken_valid", 32'(entry_valid), 32'd0);
    check("taken_count", 32'(digit_count), 32'd0);
    check("taken_bcd", 32'(entry_bcd), 32'd0);
    check("taken_value_hold", 32'(entry_value), 32'd1234);

    // Glitch rejection: 5 for 2 cycles
    base = ack_rises;
    press(4'd5, 2, 10);
    check("glitch_acks", 32'(ack_rises - base), 32'd0);
    check("glitch_count", 32'(digit_count), 32'd0);

    // Overflow: seven digits, the last is dropped
    base = ack_rises;
    for (int i = 0; i < 6; i++) press(4'd9, 10, 10);
    press(4'd8, 10, 10);
    check("ovf_acks", 32'(ack_rises - base), 32'd7);
    check("ovf_bcd", 32'(entry_bcd), 32'h999999);
    check("ovf_count", 32'(digit_count), 32'd6);
    buttonPressed = 4'd11;
    cycles(10);
    buttonPressed = 4'd13;
    wait_valid("ovf_valid", n);
    check("ovf_value", 32'(entry_value), 32'd999999);
    take();

    // '*' edit: 4,5,*,6,#
    press(4'd4, 10, 10);
    press(4'd5, 10, 10);
    press(4'd10, 10, 10);
    press(4'd6, 10, 10);
    buttonPressed = 4'd11;
    cycles(10);
    buttonPressed = 4'd13;
    wait_valid("edit_valid", n);
`ifdef KEYPAD_BACKSPACE_EN
    check("edit_value", 32'(entry_value), 32'd46);
`else
    check("edit_value", 32'(entry_value), 32'd6);
`endif
    take();

    // '#' with no digits, then invalid code 12
    base = ack_rises;
    press(4'd11, 10, 20);
    check("empty_enter_acks", 32'(ack_rises - base), 32'd1);
    check("empty_enter_valid", 32'(entry_valid), 32'd0);
    base = ack_rises;
    press(4'd12, 20, 10);
    check("code12_acks", 32'(ack_rises - base), 32'd0);
    check("code12_count", 32'(digit_count), 32'd0);

    // Reset during conversion of "12"
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    buttonPressed = 4'd11;
    cycles(10);
    buttonPressed = 4'd13;
    wait_ack("rst_enter_ack_fall", 1'b0);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    check("rst_ack", acknowledgeKey, 32'd0);
    check("rst_valid", 32'(entry_valid), 32'd0);
    check("rst_value", 32'(entry_value), 32'd0);
    check("rst_bcd", 32'(entry_bcd), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    reset = 1'b0;
    cycles(10);
    check("rst_no_valid_after", 32'(entry_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
